// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between two requesters.
// Ports: clock/reset, req0_*/req1_* valid-ready request channels,
//        rsp0_*/rsp1_* read responses, ram_* BRAM pins,
//        grant0_count/grant1_count saturating grant counters, clear_counts.
module bram_arbiter #(
    parameter int RAM_WIDTH     = 16,
    parameter int RAM_ADDR_BITS = 16,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic                     req0_write,
    input  logic [RAM_ADDR_BITS-1:0] req0_addr,
    input  logic [RAM_WIDTH-1:0]     req0_wdata,
    output logic                     rsp0_valid,
    output logic [RAM_WIDTH-1:0]     rsp0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic                     req1_write,
    input  logic [RAM_ADDR_BITS-1:0] req1_addr,
    input  logic [RAM_WIDTH-1:0]     req1_wdata,
    output logic                     rsp1_valid,
    output logic [RAM_WIDTH-1:0]     rsp1_data,
    output logic                     ram_enable,
    output logic                     ram_write_enable,
    output logic [RAM_ADDR_BITS-1:0] ram_address,
    output logic [RAM_WIDTH-1:0]     ram_input_data,
    input  logic [RAM_WIDTH-1:0]     ram_output_data,
    output logic [CNT_WIDTH-1:0]     grant0_count,
    output logic [CNT_WIDTH-1:0]     grant1_count,
    input  logic                     clear_counts
);

    logic                 last_grant_q, last_grant_d;
    logic                 pend_rd_q, pend_rd_d;
    logic                 pend_id_q, pend_id_d;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;
    logic                 grant0, grant1;

    // On contention the requester that did not win last time goes next.
    assign grant0 = req0_valid & (~req1_valid | last_grant_q) & ~reset;
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q) & ~reset;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        ram_enable       = 1'b0;
        ram_write_enable = 1'b0;
        ram_address      = '0;
        ram_input_data   = '0;
        if (grant0) begin
            ram_enable       = 1'b1;
            ram_write_enable = req0_write;
            ram_address      = req0_addr;
            ram_input_data   = req0_wdata;
        end else if (grant1) begin
            ram_enable       = 1'b1;
            ram_write_enable = req1_write;
            ram_address      = req1_addr;
            ram_input_data   = req1_wdata;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end
        pend_rd_d = (grant0 & ~req0_write) | (grant1 & ~req1_write);
        pend_id_d = grant1;
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (clear_counts) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (grant0 && (cnt0_q != '1)) begin
                cnt0_d = cnt0_q + 1'b1;
            end
            if (grant1 && (cnt1_q != '1)) begin
                cnt1_d = cnt1_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            pend_rd_q    <= 1'b0;
            pend_id_q    <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            pend_rd_q    <= pend_rd_d;
            pend_id_q    <= pend_id_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    // Gating with reset kills a response owed to a read accepted
    // in the cycle just before reset rose.
    assign rsp0_valid = pend_rd_q & ~pend_id_q & ~reset;
    assign rsp1_valid = pend_rd_q & pend_id_q & ~reset;
    assign rsp0_data  = rsp0_valid ? ram_output_data : '0;
    assign rsp1_data  = rsp1_valid ? ram_output_data : '0;

    assign grant0_count = cnt0_q;
    assign grant1_count = cnt1_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed self-checking bench for bram_arbiter with a BRAM model.
// A second instance with 4-bit counters checks counter saturation.
module tb_bram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_write;
    logic [15:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_write;
    logic [15:0] req1_addr, req1_wdata;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_data, rsp1_data;
    logic        ram_enable, ram_write_enable;
    logic [15:0] ram_address, ram_input_data;
    logic [15:0] ram_output_data;
    logic [31:0] grant0_count, grant1_count;
    logic        clear_counts;

    logic        s_req0_ready, s_req1_ready;
    logic        s_rsp0_valid, s_rsp1_valid;
    logic [15:0] s_rsp0_data, s_rsp1_data;
    logic        s_ram_enable, s_ram_write_enable;
    logic [15:0] s_ram_address, s_ram_input_data;
    logic [3:0]  s_grant0_count, s_grant1_count;

    logic        pre_we;
    logic [15:0] pre_addr, pre_data;
    logic [15:0] mem [0:255];

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    // Single-port BRAM, registered read, read-first on write.
    always @(posedge clock) begin
        if (pre_we) begin
            mem[pre_addr[7:0]] <= pre_data;
        end else if (ram_enable) begin
            if (ram_write_enable) begin
                mem[ram_address[7:0]] <= ram_input_data;
            end
            ram_output_data <= mem[ram_address[7:0]];
        end
    end

    bram_arbiter dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .ram_enable(ram_enable),
        .ram_write_enable(ram_write_enable),
        .ram_address(ram_address),
        .ram_input_data(ram_input_data),
        .ram_output_data(ram_output_data),
        .grant0_count(grant0_count), .grant1_count(grant1_count),
        .clear_counts(clear_counts)
    );

    bram_arbiter #(.CNT_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready),
        .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata),
        .rsp0_valid(s_rsp0_valid), .rsp0_data(s_rsp0_data),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready),
        .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata),
        .rsp1_valid(s_rsp1_valid), .rsp1_data(s_rsp1_data),
        .ram_enable(s_ram_enable),
        .ram_write_enable(s_ram_write_enable),
        .ram_address(s_ram_address),
        .ram_input_data(s_ram_input_data),
        .ram_output_data(ram_output_data),
        .grant0_count(s_grant0_count), .grant1_count(s_grant1_count),
        .clear_counts(clear_counts)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clr_in;
        req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
        clear_counts = 0;
    endtask

    task automatic do_reset;
        reset = 1;
        clr_in();
        tick();
        tick();
        reset = 0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_we = 1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        clr_in();
        req0_valid = 1; req1_valid = 1; req0_addr = 16'h0055;
        tick();
        @(negedge clock);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got %b%b want 00",
                     req0_ready, req1_ready);
        end
        checks++;
        if (ram_enable !== 1'b0 || ram_address !== 16'h0) begin
            failures++;
            $display("FAIL reset_ram en=%b addr=%h want 0/0000",
                     ram_enable, ram_address);
        end
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
            grant0_count !== 0 || grant1_count !== 0) begin
            failures++;
            $display("FAIL reset_state rsp=%b%b cnt=%0d/%0d want 00 0/0",
                     rsp0_valid, rsp1_valid, grant0_count, grant1_count);
        end
        tick();
        reset = 0;
        clr_in();
    endtask

    task automatic test_single_read;
        do_reset();
        preload(16'h0010, 16'hABCD);
        req0_valid = 1; req0_write = 0; req0_addr = 16'h0010;
        @(negedge clock);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0 ||
            ram_enable !== 1'b1 || ram_write_enable !== 1'b0 ||
            ram_address !== 16'h0010) begin
            failures++;
            $display("FAIL single_grant rdy=%b%b en=%b we=%b a=%h want 10 1 0 0010",
                     req0_ready, req1_ready, ram_enable,
                     ram_write_enable, ram_address);
        end
        tick();
        req0_valid = 0;
        @(negedge clock);
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 16'hABCD) begin
            failures++;
            $display("FAIL single_rsp v=%b d=%h want 1 abcd",
                     rsp0_valid, rsp0_data);
        end
        checks++;
        if (rsp1_valid !== 1'b0 || rsp1_data !== 16'h0 ||
            grant0_count !== 1) begin
            failures++;
            $display("FAIL single_side rsp1=%b d1=%h cnt0=%0d want 0 0000 1",
                     rsp1_valid, rsp1_data, grant0_count);
        end
        tick();
        @(negedge clock);
        checks++;
        if (rsp0_valid !== 1'b0 || rsp0_data !== 16'h0) begin
            failures++;
            $display("FAIL single_after v=%b d=%h want 0 0000",
                     rsp0_valid, rsp0_data);
        end
        tick();
    endtask

    task automatic test_contention;
        logic        pid;
        logic [15:0] pdat;
        do_reset();
        preload(16'h0040, 16'h1111);
        preload(16'h0041, 16'h2222);
        req0_valid = 1; req0_addr = 16'h0040;
        req1_valid = 1; req1_addr = 16'h0041;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            if (i < 6) begin
                checks++;
                if (req0_ready !== (i % 2 == 0) ||
                    req1_ready !== (i % 2 == 1)) begin
                    failures++;
                    $display("FAIL rr_grant cyc=%0d got %b%b want %b%b",
                             i, req0_ready, req1_ready,
                             (i % 2 == 0), (i % 2 == 1));
                end
            end
            if (i > 0) begin
                pid  = ((i - 1) % 2 == 1);
                pdat = pid ? 16'h2222 : 16'h1111;
                checks++;
                if (rsp0_valid !== !pid || rsp1_valid !== pid ||
                    (pid ? rsp1_data : rsp0_data) !== pdat) begin
                    failures++;
                    $display("FAIL rr_rsp cyc=%0d v=%b%b d0=%h d1=%h want id=%0d d=%h",
                             i, rsp0_valid, rsp1_valid, rsp0_data,
                             rsp1_data, pid, pdat);
                end
            end
            tick();
            if (i == 5) begin
                req0_valid = 0;
                req1_valid = 0;
            end
        end
        checks++;
        if (grant0_count !== 3 || grant1_count !== 3) begin
            failures++;
            $display("FAIL rr_counts got %0d/%0d want 3/3",
                     grant0_count, grant1_count);
        end
    endtask

    task automatic test_raw;
        do_reset();
        req1_valid = 1; req1_write = 1;
        req1_addr = 16'h0020; req1_wdata = 16'h1234;
        @(negedge clock);
        checks++;
        if (req1_ready !== 1'b1 || ram_write_enable !== 1'b1 ||
            ram_address !== 16'h0020 || ram_input_data !== 16'h1234) begin
            failures++;
            $display("FAIL raw_write rdy1=%b we=%b a=%h d=%h want 1 1 0020 1234",
                     req1_ready, ram_write_enable, ram_address,
                     ram_input_data);
        end
        tick();
        req1_valid = 0; req1_write = 0;
        req0_valid = 1; req0_addr = 16'h0020;
        @(negedge clock);
        checks++;
        if (req0_ready !== 1'b1 || rsp1_valid !== 1'b0 ||
            rsp0_valid !== 1'b0) begin
            failures++;
            $display("FAIL raw_read rdy0=%b rsp=%b%b want 1 00",
                     req0_ready, rsp0_valid, rsp1_valid);
        end
        tick();
        req0_valid = 0;
        @(negedge clock);
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 16'h1234 ||
            rsp1_valid !== 1'b0) begin
            failures++;
            $display("FAIL raw_rsp v0=%b d0=%h v1=%b want 1 1234 0",
                     rsp0_valid, rsp0_data, rsp1_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        req0_valid = 1; req0_addr = 16'h0010;
        @(negedge clock);
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_accept rdy0=%b want 1", req0_ready);
        end
        tick();
        reset = 1;
        req0_valid = 1; req1_valid = 1;
        @(negedge clock);
        checks++;
        if (rsp0_valid !== 1'b0 || req0_ready !== 1'b0 ||
            req1_ready !== 1'b0 || ram_enable !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset rsp0=%b rdy=%b%b en=%b want 0 00 0",
                     rsp0_valid, req0_ready, req1_ready, ram_enable);
        end
        tick();
        reset = 0;
        req0_valid = 0; req1_valid = 0;
        @(negedge clock);
        checks++;
        if (rsp0_valid !== 1'b0 || grant0_count !== 0 ||
            grant1_count !== 0) begin
            failures++;
            $display("FAIL mid_after rsp0=%b cnt=%0d/%0d want 0 0/0",
                     rsp0_valid, grant0_count, grant1_count);
        end
        tick();
        req0_valid = 1; req1_valid = 1;
        @(negedge clock);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_contend got %b%b want 10",
                     req0_ready, req1_ready);
        end
        tick();
        clr_in();
        tick();
    endtask

    task automatic test_saturate;
        do_reset();
        req0_valid = 1; req0_addr = 16'h0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14 || i == 15) begin
                @(negedge clock);
                checks++;
                if (s_grant0_count !== 4'hF) begin
                    failures++;
                    $display("FAIL sat_edge n=%0d got %0d want 15",
                             i + 1, s_grant0_count);
                end
            end
        end
        @(negedge clock);
        checks++;
        if (s_grant0_count !== 4'hF || grant0_count !== 20) begin
            failures++;
            $display("FAIL sat_final got %0d/%0d want 15/20",
                     s_grant0_count, grant0_count);
        end
        clear_counts = 1;
        @(negedge clock);
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL clr_grant rdy0=%b want 1", req0_ready);
        end
        tick();
        clear_counts = 0;
        req0_valid = 0;
        @(negedge clock);
        checks++;
        if (s_grant0_count !== 4'h0 || grant0_count !== 0) begin
            failures++;
            $display("FAIL clr_count got %0d/%0d want 0/0",
                     s_grant0_count, grant0_count);
        end
        tick();
    endtask

    task automatic test_idle;
        do_reset();
        req0_valid = 1; req0_addr = 16'h0002;
        tick();
        req0_valid = 0;
        req0_addr = 16'hBEEF; req0_wdata = 16'hCAFE; req0_write = 1;
        req1_addr = 16'h7777; req1_wdata = 16'h5555; req1_write = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (ram_enable !== 1'b0 || ram_write_enable !== 1'b0 ||
                ram_address !== 16'h0 || ram_input_data !== 16'h0) begin
                failures++;
                $display("FAIL idle_pins cyc=%0d en=%b we=%b a=%h d=%h want 0 0 0000 0000",
                         i, ram_enable, ram_write_enable, ram_address,
                         ram_input_data);
            end
            tick();
        end
        req0_write = 0; req1_write = 0;
        req0_valid = 1; req1_valid = 1;
        @(negedge clock);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_contend got %b%b want 01",
                     req0_ready, req1_ready);
        end
        tick();
        clr_in();
    endtask

    initial begin
        pre_we = 0; pre_addr = 0; pre_data = 0;
        reset = 1;
        clr_in();
        test_reset();
        test_single_read();
        test_contention();
        test_raw();
        test_reset_mid();
        test_saturate();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port block RAM (1-cycle registered read, read-first on write) between image-processing stages, e.g. a pixel reader and a result writer.
- Accepts valid/ready requests and drives the RAM enable, write, address and data pins.
- Returns read data to the issuing requester one cycle after acceptance.
- Keeps saturating per-requester grant counters for bandwidth profiling.

Parameters:
- RAM_WIDTH, 16, data width in bits.
- RAM_ADDR_BITS, 16, address width in bits.
- CNT_WIDTH, 32, width of each grant counter.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request is accepted this cycle.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  RAM_ADDR_BITS  request address.
- req0_wdata  in  RAM_WIDTH  write data.
- rsp0_valid  out  1  read data for requester 0 is valid.
- rsp0_data  out  RAM_WIDTH  read data.
- req1_valid, req1_ready, req1_write, req1_addr, req1_wdata, rsp1_valid, rsp1_data: same as requester 0, for requester 1.
- ram_enable  out  1  RAM enable.
- ram_write_enable  out  1  RAM write enable.
- ram_address  out  RAM_ADDR_BITS  RAM address.
- ram_input_data  out  RAM_WIDTH  RAM write data.
- ram_output_data  in  RAM_WIDTH  RAM registered read data.
- grant0_count  out  CNT_WIDTH  accepted requests from requester 0.
- grant1_count  out  CNT_WIDTH  accepted requests from requester 1.
- clear_counts  in  1  synchronous clear of both grant counters.

Behaviour:
- Arbitration is combinational in the current cycle.
- Register last_grant holds 0 or 1; reset value is 1, so requester 0 wins the first contention.
- Only req0_valid: grant 0. Only req1_valid: grant 1.
- Both valid: grant the requester that is not last_grant.
- Neither valid: no grant; last_grant is unchanged.
- At most one reqN_ready is high per cycle. reqN_ready = reqN_valid & granted & !reset.
- Handshake: a request is accepted when valid and ready are both high.
- A requester must hold valid, write, addr and wdata stable until accepted. The arbiter never revokes a grant mid-cycle.
- Valid may be high continuously; back-to-back acceptance of one requester is allowed when the other is idle.
- RAM pins are combinational from the winning request:
  - ram_enable = any grant.
  - ram_write_enable = winner's write bit.
  - ram_address and ram_input_data = winner's addr and wdata.
  - With no grant: ram_enable = 0, ram_write_enable = 0, address and data = 0.
- Reads:
  - On an accepted read, register pend_rd = 1 and pend_id = winner.
  - In the next cycle, rspN_valid = pend_rd & (pend_id == N), and rspN_data = ram_output_data.
  - Read latency is exactly 1 cycle after acceptance; there is no response backpressure.
  - rspN_data is 0 whenever rspN_valid is 0.
- Writes produce no response; acceptance is the completion.
- Read-after-write to the same address in the next cycle returns the new data (the write has committed).
- Grant counters:
  - Increment by 1 on each accepted request from that requester.
  - Saturate at all-ones; no wrap.
  - clear_counts zeroes both counters and has priority over an increment in the same cycle.
- Reset (synchronous, any cycle, including mid-operation):
  - last_grant = 1, pend_rd = 0, both counters = 0.
  - All readies and rsp_valids are 0 and ram_enable = 0 while reset is high.
  - A read accepted in the cycle before reset produces no response.
- The arbiter holds no per-requester state beyond pend_id, so alternating read and write streams interleave freely.

Test Plan:
- Reset, then req0 read addr 0x0010 alone (RAM preloaded 0x0010 = 0xABCD) -> req0_ready = 1 in cycle T; rsp0_valid = 1 with 0xABCD in T+1; rsp1_valid stays 0; grant0_count = 1.
- Both valid continuously for 6 cycles (reads) -> grants alternate 0,1,0,1,0,1; each rsp arrives on the correct port one cycle later; both counts = 3.
- req1 write 0x0020 = 0x1234 in cycle T, req0 read 0x0020 in T+1 -> rsp0_data = 0x1234 in T+2; req1 gets no response.
- req0 read accepted in T, reset asserted in T+1 -> rsp0_valid = 0 in T+1 and T+2; counts = 0; after reset release, contention is won by requester 0.
- CNT_WIDTH = 4: 20 accepted req0 requests -> grant0_count saturates at 15; clear_counts with a simultaneous grant -> count = 0.
- No requests for 5 cycles -> ram_enable = 0, ram_write_enable = 0, ram_address = 0, last_grant unchanged (next contention goes to the non-last requester).
